// File: rtl/pool_stride_sel_if.sv
// Stream bundle between the max-pool stage, the stride selector and the
// next layer's row buffer.
interface pool_stride_sel_if #(
  parameter int ch_out = 128
);
  logic              frame_start;
  logic              stream_in_en;
  logic [ch_out-1:0] pool_in;
  logic [ch_out-1:0] stream_out;
  logic              stream_out_en;
  logic              frame_end;

  // Handshake: no backpressure. stream_in_en accepts a pixel in the cycle it is
  // high; stream_out is valid exactly in cycles where stream_out_en is high and
  // the consumer must take it then. frame_end only ever rides on a strobe.
  modport master (
    output frame_start,
    output stream_in_en,
    output pool_in,
    input  stream_out,
    input  stream_out_en,
    input  frame_end
  );

  modport slave (
    input  frame_start,
    input  stream_in_en,
    input  pool_in,
    output stream_out,
    output stream_out_en,
    output frame_end
  );
endinterface

// File: rtl/pool_stride_sel.sv
// Keeps only max-pool outputs that close a full non-overlapping window, with the
// window-complete flag delayed to line up with the max-pool latency.
module pool_stride_sel #(
  parameter int ch_out      = 128,
  parameter int k_s_maxpool = 2,
  parameter int w_in        = 32,
  parameter int h_in        = 32,
  parameter int in_lat      = 1
) (
  input  logic               clk,
  input  logic               reset,
  pool_stride_sel_if.slave   bus
);

  localparam int col_w = (w_in > 1) ? $clog2(w_in) : 1;
  localparam int row_w = (h_in > 1) ? $clog2(h_in) : 1;
  localparam int k_w   = (k_s_maxpool > 1) ? $clog2(k_s_maxpool) : 1;
  localparam int n_out = (w_in / k_s_maxpool) * (h_in / k_s_maxpool);
  localparam int oc_w  = (n_out > 1) ? $clog2(n_out) : 1;

  localparam logic [col_w-1:0] col_last = col_w'(w_in - 1);
  localparam logic [row_w-1:0] row_last = row_w'(h_in - 1);
  localparam logic [k_w-1:0]   k_last   = k_w'(k_s_maxpool - 1);
  localparam logic [oc_w-1:0]  oc_last  = oc_w'(n_out - 1);

  logic              frame_start;
  logic              stream_in_en;
  logic [ch_out-1:0] pool_in;

  assign frame_start  = bus.frame_start;
  assign stream_in_en = bus.stream_in_en;
  assign pool_in      = bus.pool_in;

  logic [col_w-1:0]  col_q, col_d, col_b;
  logic [row_w-1:0]  row_q, row_d, row_b;
  logic [k_w-1:0]    kc_q, kc_d, kc_b;
  logic [k_w-1:0]    kr_q, kr_d, kr_b;
  logic [oc_w-1:0]   oc_q, oc_d;
  logic [ch_out-1:0] stream_out_q, stream_out_d;
  logic              stream_out_en_q, stream_out_en_d;
  logic              frame_end_q, frame_end_d;
  logic              hit;
  logic              hit_d;

  // frame_start rebases the raster to (0,0) before the current pixel is counted.
  always_comb begin
    col_b = frame_start ? '0 : col_q;
    row_b = frame_start ? '0 : row_q;
    kc_b  = frame_start ? '0 : kc_q;
    kr_b  = frame_start ? '0 : kr_q;
    col_d = col_b;
    row_d = row_b;
    kc_d  = kc_b;
    kr_d  = kr_b;
    hit   = stream_in_en && (kc_b == k_last) && (kr_b == k_last);
    if (stream_in_en) begin
      if (col_b == col_last) begin
        col_d = '0;
        kc_d  = '0;
        if (row_b == row_last) begin
          row_d = '0;
          kr_d  = '0;
        end else begin
          row_d = row_b + row_w'(1);
          kr_d  = (kr_b == k_last) ? '0 : kr_b + k_w'(1);
        end
      end else begin
        col_d = col_b + col_w'(1);
        kc_d  = (kc_b == k_last) ? '0 : kc_b + k_w'(1);
      end
    end
  end

  generate
    if (in_lat == 0) begin : g_no_lat
      assign hit_d = hit;
    end else begin : g_lat
      logic [in_lat-1:0] dl_q, dl_d;

      // A pixel accepted together with frame_start survives the flush.
      always_comb begin
        dl_d = dl_q << 1;
        if (frame_start) dl_d = '0;
        dl_d[0] = hit;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) dl_q <= '0;
        else        dl_q <= dl_d;
      end

      assign hit_d = dl_q[in_lat-1];
    end
  endgenerate

  always_comb begin
    stream_out_d    = stream_out_q;
    stream_out_en_d = 1'b0;
    frame_end_d     = 1'b0;
    oc_d            = oc_q;
    if (frame_start) begin
      oc_d = '0;
    end else if (hit_d) begin
      stream_out_d    = pool_in;
      stream_out_en_d = 1'b1;
      frame_end_d     = (oc_q == oc_last);
      oc_d            = (oc_q == oc_last) ? '0 : oc_q + oc_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q           <= '0;
      row_q           <= '0;
      kc_q            <= '0;
      kr_q            <= '0;
      oc_q            <= '0;
      stream_out_q    <= '0;
      stream_out_en_q <= 1'b0;
      frame_end_q     <= 1'b0;
    end else begin
      col_q           <= col_d;
      row_q           <= row_d;
      kc_q            <= kc_d;
      kr_q            <= kr_d;
      oc_q            <= oc_d;
      stream_out_q    <= stream_out_d;
      stream_out_en_q <= stream_out_en_d;
      frame_end_q     <= frame_end_d;
    end
  end

  assign bus.stream_out    = stream_out_q;
  assign bus.stream_out_en = stream_out_en_q;
  assign bus.frame_end     = frame_end_q;

endmodule

// File: tb/tb_pool_stride_sel.sv
// Drives four differently-configured selectors with one shared stream and checks
// each against a raster-position model of which pixels close a full window.
module tb_pool_stride_sel;

  localparam int NI = 4;

  function automatic int k_of(input int i);
    case (i) 0: return 2; 1: return 2; 2: return 1; default: return 2; endcase
  endfunction
  function automatic int w_of(input int i);
    case (i) 0: return 4; 1: return 5; 2: return 4; default: return 6; endcase
  endfunction
  function automatic int h_of(input int i);
    case (i) 0: return 4; 1: return 5; 2: return 1; default: return 5; endcase
  endfunction
  function automatic int lat_of(input int i);
    case (i) 0: return 1; 1: return 1; 2: return 0; default: return 3; endcase
  endfunction
  function automatic int n_of(input int i);
    return (w_of(i) / k_of(i)) * (h_of(i) / k_of(i));
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_fs  = 1'b0;
  logic       in_en  = 1'b0;
  logic [7:0] in_pin = '0;

  logic [7:0] out_a [NI];
  logic       en_a  [NI];
  logic       fe_a  [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      pool_stride_sel_if #(.ch_out(8)) bus ();
      assign bus.frame_start  = in_fs;
      assign bus.stream_in_en = in_en;
      assign bus.pool_in      = in_pin;
      assign out_a[g] = bus.stream_out;
      assign en_a[g]  = bus.stream_out_en;
      assign fe_a[g]  = bus.frame_end;
      pool_stride_sel #(
        .ch_out(8), .k_s_maxpool(k_of(g)), .w_in(w_of(g)),
        .h_in(h_of(g)), .in_lat(lat_of(g))
      ) u_dut (
        .clk(clk), .reset(rst_n), .bus(bus)
      );
    end
  endgenerate

  // scoreboard / model state
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         pos [NI];
  int         oc_m [NI];
  int         pend [NI][$];
  logic [7:0] exp_out [NI];
  bit         exp_en [NI];
  bit         exp_fe [NI];
  int         strobe_cnt [NI];
  int         fe_cnt [NI];
  logic [7:0] got0 [$];
  logic [7:0] exp_q [$];
  int         idx = 0;
  logic [7:0] last_idx = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      pos[i] = 0; oc_m[i] = 0; pend[i].delete();
      exp_out[i] = '0; exp_en[i] = 1'b0; exp_fe[i] = 1'b0;
    end
  endtask

  // One rising edge as the selector's rules describe it.
  task automatic model_edge(input bit en, input bit fs, input logic [7:0] pin);
    int x, y, k;
    for (int i = 0; i < NI; i++) begin
      k = k_of(i);
      if (fs) begin
        pend[i].delete(); pos[i] = 0; oc_m[i] = 0;
      end
      if (en) begin
        x = pos[i] % w_of(i);
        y = pos[i] / w_of(i);
        if ((x % k == k - 1) && (y % k == k - 1)) pend[i].push_back(cyc + lat_of(i));
        pos[i] = (pos[i] + 1) % (w_of(i) * h_of(i));
      end
      exp_en[i] = 1'b0;
      exp_fe[i] = 1'b0;
      if (pend[i].size() > 0 && pend[i][0] == cyc) begin
        void'(pend[i].pop_front());
        if (!fs) begin
          exp_en[i] = 1'b1;
          exp_out[i] = pin;
          oc_m[i]++;
          if (oc_m[i] == n_of(i)) begin
            exp_fe[i] = 1'b1;
            oc_m[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("en%0d", i), en_a[i], exp_en[i]);
      check($sformatf("fe%0d", i), fe_a[i], exp_fe[i]);
      check($sformatf("out%0d", i), out_a[i], exp_out[i]);
      if (en_a[i]) strobe_cnt[i]++;
      if (fe_a[i]) fe_cnt[i]++;
    end
    if (en_a[0]) got0.push_back(out_a[0]);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NI; i++) begin
      strobe_cnt[i] = 0; fe_cnt[i] = 0;
    end
    got0.delete();
    idx = 0;
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input bit en, input bit fs, input logic [7:0] pin);
    in_en = en; in_fs = fs; in_pin = pin;
    @(posedge clk);
    model_edge(en, fs, pin);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  // pool_in carries the index of the previously accepted pixel (1-cycle max-pool)
  task automatic px(input bit en, input bit fs);
    step(en, fs, last_idx);
    if (en) begin
      last_idx = 8'(idx);
      idx++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic check_values0();
    exp_q = '{8'd5, 8'd7, 8'd13, 8'd15};
    check("val0_cnt", got0.size(), 4);
    while (got0.size() > 0 && exp_q.size() > 0) check("val0", got0.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // continuous 16-pixel frame
    clear_obs();
    repeat (16) px(1'b1, 1'b0);
    repeat (4) px(1'b0, 1'b0);
    check("p1_strobes0", strobe_cnt[0], 4);
    check("p1_fe0", fe_cnt[0], 1);
    check("p1_strobes2", strobe_cnt[2], 16);
    check("p1_fe2", fe_cnt[2], 4);
    check_values0();

    // enable toggling every cycle
    clear_obs();
    for (int j = 0; j < 32; j++) px(j % 2 == 0, 1'b0);
    repeat (4) px(1'b0, 1'b0);
    check("p2_strobes0", strobe_cnt[0], 4);
    check("p2_fe0", fe_cnt[0], 1);
    check_values0();

    // two 5x5 frames with partial windows
    clear_obs();
    px(1'b1, 1'b1);
    repeat (49) px(1'b1, 1'b0);
    repeat (4) px(1'b0, 1'b0);
    check("p3_strobes1", strobe_cnt[1], 8);
    check("p3_fe1", fe_cnt[1], 2);

    // reset after pixel 9, then a fresh frame
    clear_obs();
    px(1'b1, 1'b1);
    repeat (9) px(1'b1, 1'b0);
    do_reset();
    clear_obs();
    repeat (16) px(1'b1, 1'b0);
    repeat (4) px(1'b0, 1'b0);
    check("p4_strobes0", strobe_cnt[0], 4);
    check("p4_fe0", fe_cnt[0], 1);
    check_values0();

    // frame_start together with pixel 6
    clear_obs();
    px(1'b1, 1'b1);
    repeat (5) px(1'b1, 1'b0);
    px(1'b1, 1'b1);
    repeat (15) px(1'b1, 1'b0);
    repeat (4) px(1'b0, 1'b0);
    check("p5_strobes0", strobe_cnt[0], 4);
    check("p5_fe0", fe_cnt[0], 1);

    // k=1, zero latency row
    px(1'b0, 1'b1);
    clear_obs();
    repeat (4) px(1'b1, 1'b0);
    px(1'b0, 1'b0);
    check("p6_strobes2", strobe_cnt[2], 4);
    check("p6_fe2", fe_cnt[2], 1);

    // randomized traffic
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 89) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_stride_sel.md
Name: pool_stride_sel

Overview:
- Stage directly downstream of the max-pool stage.
- The max-pool output is recomputed every enabled pixel, but only pixels closing a non-overlapping k_s x k_s window carry a valid pooled result.
- This block tracks the input raster position and delays the window-complete flag to match max-pool latency.
- It registers only the valid pooled vectors, with an output strobe and an end-of-frame marker, for the next layer's row buffer.

Parameters:
- ch_out, 128, channel count, equal to the bit width of the binary stream.
- k_s_maxpool, 2, pooling window size and stride; must be at least 1.
- w_in, 32, input row width in pixels.
- h_in, 32, input frame height in rows.
- in_lat, 1, clock cycles from an accepted stream_in_en to the max-pool output reflecting that pixel; range 0..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  synchronous restart of raster tracking; single-cycle pulse.
- stream_in_en  input  1  pixel-accept enable; the same signal that drives the max-pool stage.
- pool_in  input  ch_out  max-pool stream_out.
- stream_out  output  ch_out  registered pooled pixel.
- stream_out_en  output  1  one-cycle strobe; stream_out is valid when high.
- frame_end  output  1  one-cycle strobe, coincident with the last stream_out_en of a frame.

Behaviour:
- Reset (reset=0, async): stream_out=0, stream_out_en=0, frame_end=0. All counters and the delay line clear to 0.
- Input raster counters advance only on stream_in_en=1:
  - col: 0..w_in-1.
  - row: 0..h_in-1.
  - kc and kr: 0..k_s_maxpool-1 sub-counters.
  - col wraps to 0 and row increments; kc resets to 0 at each col wrap.
  - At col=w_in-1 and row=h_in-1, everything wraps to (0,0).
- hit = stream_in_en & (kc==k_s_maxpool-1) & (kr==k_s_maxpool-1), evaluated with pre-increment values.
- Partial windows: if w_in or h_in is not a multiple of k_s_maxpool, trailing columns and rows never produce hit.
  - Outputs per frame: N = floor(w_in/k_s_maxpool) * floor(h_in/k_s_maxpool).
- Delay line: in_lat-deep shift register of hit, shifting every clock regardless of stream_in_en. hit_d is the tap at depth in_lat; with in_lat=0, hit_d=hit.
- Output register, on each clock:
  - If hit_d: stream_out <= pool_in, stream_out_en <= 1.
  - Otherwise: stream_out holds, stream_out_en <= 0.
- Latency: stream_out_en rises in the cycle after pool_in is sampled, i.e. in_lat+1 cycles after the accepted enable edge of the window-closing pixel.
- Output counter oc: 0..N-1, increments on each hit_d.
  - frame_end <= hit_d & (oc==N-1); oc wraps to 0 at the same time.
- frame_start=1 clears col, row, kc, kr, oc and the delay line.
  - Results in flight are discarded, and stream_out_en is forced to 0 next cycle.
  - If stream_in_en is high in the same cycle, that pixel is position (0,0) and counters post-increment from there.
- Back-to-back windows (k_s_maxpool=1): hit is asserted every enabled cycle, and stream_out_en may stay high continuously.
- stream_in_en gaps: counters hold. The delay line still shifts, so output timing is always relative to the enable edge, not to the next enable.
- No backpressure; the consumer must accept every strobe.

Test Plan:
- ch_out=4, k_s_maxpool=2, w_in=4, h_in=4, in_lat=1; continuous stream_in_en for 16 cycles; pool_in driven with the pixel index.
  -> Exactly 4 strobes, at input indices 5, 7, 13, 15, each 2 cycles after acceptance.
  -> stream_out = 5, 7, 13, 15; frame_end only with the value 15.
- Same configuration with stream_in_en toggled 1/0 every cycle.
  -> Same 4 output values.
  -> Each strobe 2 cycles after its enabling edge; strobes never repeated.
- w_in=5, h_in=5, k_s_maxpool=2.
  -> 4 outputs per frame (column 4 and row 4 ignored).
  -> Two consecutive frames give 8 strobes and 2 frame_end pulses.
- Assert reset mid-frame (after pixel 9).
  -> Outputs go to 0 immediately.
  -> After release, a fresh 16-pixel frame gives 4 strobes and 1 frame_end.
- frame_start pulsed at pixel 6 together with stream_in_en.
  -> Pending strobe for pixel 5 is dropped if not yet emitted.
  -> The pixel is treated as (0,0); the next strobe comes at the 6th pixel after it.
- k_s_maxpool=1, in_lat=0, w_in=4, h_in=1.
  -> stream_out_en high for 4 consecutive cycles, 1 cycle after each enable; frame_end on the 4th.
